// File: rtl/audio_record_buffer.sv
// audio_record_buffer: record/playback sample store in block RAM, one write per sample_end, one read per sample_req.
// Optional looping playback enabled with `define PLAY_LOOP_EN.
module audio_record_buffer #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_end,
    input  logic                  sample_req,
    input  logic [15:0]           audio_input,
    input  logic                  rec_start,
    input  logic                  play_start,
    input  logic                  stop,
    output logic [15:0]           audio_output,
    output logic                  recording,
    output logic                  playing,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   rec_length
);
    typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   rec_length_q, rec_length_d;
    logic                  full_q, full_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [15:0]           audio_output_q, audio_output_d;
    logic                  we, last;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           ram_rd_q;
    logic [15:0]           mem [0:(1<<ADDR_WIDTH)-1];

    assign last     = rec_length_q == {1'b0, rd_addr_q} + (ADDR_WIDTH+1)'(1);
    assign mem_addr = (state_q == REC) ? wr_addr_q : rd_addr_q;

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        rec_length_d = rec_length_q;
        full_d       = full_q;
        we           = 1'b0;
        rd_valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (rec_start) begin
                    state_d      = REC;
                    wr_addr_d    = '0;
                    rec_length_d = '0;
                    full_d       = 1'b0;
                end else if (play_start && rec_length_q != '0) begin
                    state_d   = PLAY;
                    rd_addr_d = '0;
                end
            end
            REC: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (sample_end) begin
                    we           = 1'b1;
                    wr_addr_d    = wr_addr_q + ADDR_WIDTH'(1);
                    rec_length_d = rec_length_q + (ADDR_WIDTH+1)'(1);
                    if (rec_length_d[ADDR_WIDTH]) begin
                        full_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            PLAY: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (sample_req) begin
                    rd_valid_d = 1'b1;
                    rd_addr_d  = last ? '0 : rd_addr_q + ADDR_WIDTH'(1);
`ifdef PLAY_LOOP_EN
                    state_d = PLAY;
`else
                    state_d = last ? IDLE : PLAY;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        // the final word of a one-shot playback lands just after leaving PLAY
        audio_output_d = rd_valid_q ? ram_rd_q : (state_q == PLAY ? audio_output_q : '0);
    end

    always_ff @(posedge clk) begin
        if (we) mem[mem_addr] <= audio_input;
        ram_rd_q <= mem[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            rec_length_q   <= '0;
            full_q         <= 1'b0;
            rd_valid_q     <= 1'b0;
            audio_output_q <= '0;
        end else begin
            state_q        <= state_d;
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            rec_length_q   <= rec_length_d;
            full_q         <= full_d;
            rd_valid_q     <= rd_valid_d;
            audio_output_q <= audio_output_d;
        end
    end

    assign audio_output = audio_output_q;
    assign recording    = state_q == REC;
    assign playing      = state_q == PLAY;
    assign full         = full_q;
    assign rec_length   = rec_length_q;
endmodule

// File: tb/tb_audio_record_buffer.sv
// tb_audio_record_buffer: directed checks of record, playback, fill, priority and reset with ADDR_WIDTH=4.
module tb_audio_record_buffer;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_end, sample_req, rec_start, play_start, stop;
    logic [15:0]   audio_input;
    logic [15:0]   audio_output;
    logic          recording, playing, full;
    logic [AW:0]   rec_length;
    int            pass_cnt = 0;
    int            total_cnt = 0;

    audio_record_buffer #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .sample_end(sample_end), .sample_req(sample_req),
        .audio_input(audio_input), .rec_start(rec_start), .play_start(play_start),
        .stop(stop), .audio_output(audio_output), .recording(recording),
        .playing(playing), .full(full), .rec_length(rec_length)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input logic se, input logic sr, input logic rs, input logic ps,
                        input logic sp, input logic [15:0] din);
        sample_end = se; sample_req = sr; rec_start = rs; play_start = ps; stop = sp;
        audio_input = din;
        @(posedge clk); #1;
        sample_end = 0; sample_req = 0; rec_start = 0; play_start = 0; stop = 0;
    endtask

    task automatic req_and_check(input string tag, input logic [15:0] exp);
        step(0, 1, 0, 0, 0, 16'h0);
        @(posedge clk); #1;
        chk(tag, audio_output, exp);
    endtask

    initial begin
        reset = 1; sample_end = 0; sample_req = 0; rec_start = 0; play_start = 0; stop = 0;
        audio_input = 16'h0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk("rst_out", audio_output, 0);
        chk("rst_rec", recording, 0);
        chk("rst_play", playing, 0);
        chk("rst_full", full, 0);
        chk("rst_len", rec_length, 0);
        step(0, 0, 0, 1, 0, 16'h0);
        chk("empty_play_ignored", playing, 0);

        step(0, 0, 1, 0, 0, 16'h0);
        chk("rec_enter", recording, 1);
        for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 0, 16'(i));
        step(0, 0, 0, 0, 1, 16'h0);
        chk("stop_rec_low", recording, 0);
        chk("stop_len5", rec_length, 5);
        chk("stop_full0", full, 0);

        step(0, 0, 0, 1, 0, 16'h0);
        chk("play_enter", playing, 1);
        for (int i = 1; i <= 5; i++) req_and_check($sformatf("play_%0d", i), 16'(i));
`ifdef PLAY_LOOP_EN
        chk("loop_still_playing", playing, 1);
        req_and_check("loop_wrap", 16'h0001);
        step(0, 0, 0, 0, 1, 16'h0);
        chk("loop_stop", playing, 0);
`else
        chk("play_done", playing, 0);
        @(posedge clk); #1;
        chk("idle_out_zero", audio_output, 0);
`endif

        step(0, 0, 1, 1, 0, 16'h0);
        chk("prio_rec", recording, 1);
        chk("prio_not_play", playing, 0);
        chk("prio_len_clr", rec_length, 0);
        step(1, 1, 0, 0, 0, 16'h00AA);
        chk("both_strobes_len", rec_length, 1);
        @(posedge clk); #1;
        chk("both_strobes_out", audio_output, 0);
        step(0, 0, 0, 0, 1, 16'h0);
        step(0, 0, 1, 0, 1, 16'h0);
        chk("stop_beats_rec", recording, 0);
        chk("stop_beats_rec_len", rec_length, 1);

        step(0, 0, 1, 0, 0, 16'h0);
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0, 0, 16'h0100 + 16'(i));
            if (i == 14) chk("fill_not_full", full, 0);
            if (i == 15) begin
                chk("fill_full", full, 1);
                chk("fill_idle", recording, 0);
            end
        end
        chk("fill_len16", rec_length, 16);
        step(0, 0, 0, 1, 0, 16'h0);
        for (int i = 0; i < 16; i++)
            req_and_check($sformatf("fill_word_%0d", i), 16'h0100 + 16'(i));
`ifndef PLAY_LOOP_EN
        chk("fill_play_done", playing, 0);
`else
        step(0, 0, 0, 0, 1, 16'h0);
`endif

        step(0, 0, 0, 1, 0, 16'h0);
        req_and_check("midplay_1", 16'h0100);
        req_and_check("midplay_2", 16'h0101);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("midrst_play", playing, 0);
        chk("midrst_out", audio_output, 0);
        chk("midrst_len", rec_length, 0);
        step(0, 0, 0, 1, 0, 16'h0);
        chk("midrst_play_ignored", playing, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/audio_record_buffer.md
# audio_record_buffer

Record/playback sample store between the serial-to-parallel codec stage and the audio effects stage. Captures 16-bit ADC samples on the codec's `sample_end` strobe into on-chip block RAM, and replays them one per `sample_req` strobe. Runs entirely in the audio clock domain (11.2896 MHz). Driven by debounced key/switch pulses from the top level.

## Interface
- `ADDR_WIDTH`, 14, sample memory depth is 2^ADDR_WIDTH words of 16 bits.
- `clk`  in  1  audio clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `sample_end`  in  1  one-cycle strobe; `audio_input` holds a new ADC sample.
- `sample_req`  in  1  one-cycle strobe; codec requests the next DAC sample.
- `audio_input`  in  16  signed ADC sample.
- `rec_start`  in  1  one-cycle pulse; begin recording.
- `play_start`  in  1  one-cycle pulse; begin playback.
- `stop`  in  1  one-cycle pulse; abort the current operation.
- `audio_output`  out  16  signed sample to the DAC path.
- `recording`  out  1  high while in REC.
- `playing`  out  1  high while in PLAY.
- `full`  out  1  last recording filled the memory.
- `rec_length`  out  ADDR_WIDTH+1  number of samples stored.

## Operation
- States: IDLE, REC, PLAY. Reset state is IDLE.
- Command priority within one cycle: `stop` > `rec_start` > `play_start`.
- IDLE:
  - `rec_start` → REC; write address = 0; `rec_length` = 0; `full` = 0.
  - `play_start` with `rec_length` ≠ 0 → PLAY; read address = 0.
  - `play_start` with `rec_length` = 0 is ignored.
- REC:
  - On each `sample_end`, write `audio_input` at the write address, then increment the address and `rec_length`.
  - When `rec_length` reaches 2^ADDR_WIDTH, set `full` = 1 and go to IDLE.
  - `stop` → IDLE and keeps the samples already written.
  - `rec_start` and `play_start` are ignored.
- PLAY:
  - On each `sample_req`, read the word at the read address and increment the address.
  - After the word at `rec_length`−1 is issued, go to IDLE.
  - `stop` → IDLE.
  - `rec_start` and `play_start` are ignored.
- Outside PLAY, `audio_output` is forced to 16'h0000.
- `sample_end` and `sample_req` in the same cycle are both legal. Only the strobe relevant to the current state acts.
- Strobes arriving while the state changes in that same cycle are dropped.
- Arithmetic:
  - Addresses are ADDR_WIDTH bits, unsigned, and never wrap within REC.
  - `rec_length` is ADDR_WIDTH+1 bits so that the full depth is representable.
- Memory: single-port 2^ADDR_WIDTH×16 with registered read, inferred as block RAM.

## Timing
- Reset values:
  - state = IDLE
  - `audio_output` = 0, `recording` = 0, `playing` = 0, `full` = 0, `rec_length` = 0
  - both addresses = 0
- Write: the sample present in the `sample_end` cycle is written at that edge. `rec_length` increments on the same edge.
- Read latency: `audio_output` updates 2 cycles after the `sample_req` edge (RAM read + output register). It holds until the next update.
- `recording` and `playing` are registered and assert one cycle after the accepted command.
- `full` asserts on the same edge as the final write.
- Reset mid-REC or mid-PLAY returns to IDLE immediately. `rec_length` is cleared; memory contents are not cleared.

## Configuration
- `PLAY_LOOP_EN` defined:
  - In PLAY, after issuing word `rec_length`−1, the read address wraps to 0 and playback continues.
  - PLAY exits only on `stop` or `reset`.
- `PLAY_LOOP_EN` undefined: playback runs once and returns to IDLE, as described under Operation.

## Test plan
- Reset: hold `reset` 3 cycles → all outputs 0, state IDLE; `play_start` → `playing` stays 0.
- Record/stop:
  - `rec_start`, then 5 `sample_end` strobes with inputs 16'h0001..16'h0005, then `stop`.
  - Expect `rec_length` = 5, `full` = 0, `recording` low one cycle after `stop`.
- Playback:
  - After the record/stop case, `play_start`, then 5 `sample_req` strobes.
  - Expect `audio_output` = 1,2,3,4,5, each 2 cycles after its strobe.
  - Expect `playing` to drop after the 5th; with `PLAY_LOOP_EN`, a 6th strobe yields 1.
- Fill (ADDR_WIDTH=4): 20 `sample_end` strobes in REC → `full` = 1 on the 16th, `rec_length` = 16, IDLE; the remaining 4 samples are not written.
- Priority:
  - `rec_start` and `play_start` in the same IDLE cycle → REC.
  - `stop` together with `rec_start` in IDLE → remains IDLE.
  - `sample_end` together with `sample_req` in REC → exactly one write, `audio_output` stays 0.
- Reset mid-PLAY: assert `reset` after 2 of 5 samples → IDLE, `audio_output` = 0, `rec_length` = 0, and a following `play_start` is ignored.
